// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
//   arb_state_e : arbiter FSM states
//   req_id_e    : requester identity (instruction fetch or data)
//   ERR_*       : error codes reported on *_error
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    DONE
  } arb_state_e;

  typedef enum logic {
    REQ_INST,
    REQ_DATA
  } req_id_e;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Stall watchdog for the memory port arbiter.
//   clk, rstn : clock and asynchronous active-low reset
//   clear     : synchronously zero the counter (has priority over enable)
//   enable    : count one cycle of an outstanding memory access
//   expired   : counter has reached TIMEOUT-1 while enabled
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TCW     = 11
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TCW-1:0] Limit = TCW'(TIMEOUT - 1);

  logic [TCW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == Limit);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit memory port between instruction fetch and data access.
// One transaction at a time, round-robin between the two requesters, with a
// watchdog that turns a stalled access into an ERR_TIMEOUT response.
//   inst_req/inst_addr                      : fetch request (held until inst_ready)
//   inst_ready/inst_rdata/inst_error        : fetch completion (one-cycle pulse)
//   data_req/we/addr/wdata/wstrb            : data request (held until data_ready)
//   data_ready/data_rdata/data_error        : data completion (one-cycle pulse)
//   mem_valid/we/addr/wdata/wstrb           : memory request, stable until mem_ready
//   mem_ready/mem_rdata/mem_error           : memory completion
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TCW     = 11
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_ready,
  output logic [31:0] inst_rdata,
  output logic [1:0]  inst_error,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        data_ready,
  output logic [31:0] data_rdata,
  output logic [1:0]  data_error,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_error
);

  arb_state_e  state_q, state_d;
  req_id_e     grant_q, grant_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] inst_rdata_q, inst_rdata_d, data_rdata_q, data_rdata_d;
  logic [1:0]  inst_error_q, inst_error_d, data_error_q, data_error_d;
  logic        expired;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_error;

  // Word alignment discards the byte offset.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{inst_addr[1:0], data_addr[1:0]};

  mem_arb_watchdog #(
    .TIMEOUT(TIMEOUT),
    .TCW    (TCW)
  ) u_watchdog (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (!mem_valid),
    .enable (mem_valid),
    .expired(expired)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    inst_rdata_d = inst_rdata_q;
    inst_error_d = inst_error_q;
    data_rdata_d = data_rdata_q;
    data_error_d = data_error_q;
    // mem_ready takes priority over a simultaneous watchdog expiry.
    resp_rdata   = mem_ready ? mem_rdata : '0;
    resp_error   = mem_ready ? mem_error : ERR_TIMEOUT;

    unique case (state_q)
      IDLE: begin
        // On contention the requester that did not win last time goes first.
        if (inst_req && (!data_req || grant_q == REQ_DATA)) begin
          state_d = GRANT_I;
          grant_d = REQ_INST;
          we_d    = 1'b0;
          addr_d  = {inst_addr[31:2], 2'b00};
          wdata_d = '0;
          wstrb_d = '0;
        end else if (data_req) begin
          state_d = GRANT_D;
          grant_d = REQ_DATA;
          we_d    = data_we;
          addr_d  = {data_addr[31:2], 2'b00};
          wdata_d = data_wdata;
          wstrb_d = data_we ? data_wstrb : 4'b0000;
        end
      end
      GRANT_I, GRANT_D: begin
        if (mem_ready || expired) begin
          state_d = DONE;
          if (state_q == GRANT_I) begin
            inst_rdata_d = resp_rdata;
            inst_error_d = resp_error;
          end else begin
            data_rdata_d = resp_rdata;
            data_error_d = resp_error;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      grant_q      <= REQ_DATA;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      inst_rdata_q <= '0;
      inst_error_q <= ERR_OK;
      data_rdata_q <= '0;
      data_error_q <= ERR_OK;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      inst_rdata_q <= inst_rdata_d;
      inst_error_q <= inst_error_d;
      data_rdata_q <= data_rdata_d;
      data_error_q <= data_error_d;
    end
  end

  // Decoded straight from registered state so reset withdraws mem_valid at once.
  assign mem_valid  = (state_q == GRANT_I) || (state_q == GRANT_D);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = wstrb_q;
  assign inst_ready = (state_q == DONE) && (grant_q == REQ_INST);
  assign data_ready = (state_q == DONE) && (grant_q == REQ_DATA);
  assign inst_rdata = inst_rdata_q;
  assign inst_error = inst_error_q;
  assign data_rdata = data_rdata_q;
  assign data_error = data_error_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_ready;
  logic [31:0] inst_rdata;
  logic [1:0]  inst_error;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [3:0]  data_wstrb = '0;
  logic        data_ready;
  logic [31:0] data_rdata;
  logic [1:0]  data_error;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  mem_error = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .TIMEOUT(TO),
    .TCW    (4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .inst_req  (inst_req),
    .inst_addr (inst_addr),
    .inst_ready(inst_ready),
    .inst_rdata(inst_rdata),
    .inst_error(inst_error),
    .data_req  (data_req),
    .data_we   (data_we),
    .data_addr (data_addr),
    .data_wdata(data_wdata),
    .data_wstrb(data_wstrb),
    .data_ready(data_ready),
    .data_rdata(data_rdata),
    .data_error(data_error),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .mem_error (mem_error)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder: answers after resp_lat extra cycles of mem_valid.
  int          resp_lat = 0;
  logic [31:0] resp_rdata = '0;
  logic [1:0]  resp_err = '0;
  bit          stray_en = 1'b0;
  int          gcyc = 0;
  int          last_run = 0;
  logic [31:0] log_addr = '0, log_wdata = '0;
  logic        log_we = 1'b0;
  logic [3:0]  log_wstrb = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (mem_valid) begin
        if (gcyc == 0) begin
          log_addr  = mem_addr;
          log_we    = mem_we;
          log_wstrb = mem_wstrb;
          log_wdata = mem_wdata;
        end else begin
          check("mem_stable", {mem_addr, mem_wdata}, {log_addr, log_wdata});
        end
        mem_ready = (gcyc == resp_lat);
        gcyc++;
        last_run = gcyc;
      end else begin
        gcyc = 0;
        mem_ready = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      mem_rdata = (mem_valid && mem_ready) ? resp_rdata : $urandom;
      mem_error = (mem_valid && mem_ready) ? resp_err : 2'($urandom);
    end
  end

  // Reference model state
  bit          m_last_d = 1'b1;
  logic [31:0] m_ird = '0, m_drd = '0;
  logic [1:0]  m_ierr = '0, m_derr = '0;

  task automatic model_reset();
    m_last_d = 1'b1;
    m_ird = '0;
    m_drd = '0;
    m_ierr = '0;
    m_derr = '0;
  endtask

  task automatic wait_ready(output int cyc, output bit gi, output bit gd);
    cyc = 0;
    gi = 1'b0;
    gd = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      gi = inst_ready;
      gd = data_ready;
    end while (!gi && !gd && cyc < 40);
    check("ready_seen", 64'(gi | gd), 64'd1);
  endtask

  // Issue the selected requests (caller is at a negedge in IDLE) and serve all.
  task automatic round(input bit ri, input logic [31:0] ia,
                       input bit rq_d, input logic dwe, input logic [31:0] da,
                       input logic [31:0] dwd, input logic [3:0] dws,
                       input int li, input logic [31:0] mi, input logic [1:0] ei,
                       input int ld, input logic [31:0] md, input logic [1:0] ed);
    bit pend_i, pend_d, first, win_d, tmo, gi, gd;
    int cyc, lat;
    logic [31:0] rdv;
    logic [1:0]  erv;
    pend_i = ri;
    pend_d = rq_d;
    first = 1'b1;
    inst_req = ri;
    inst_addr = ia;
    data_req = rq_d;
    data_we = dwe;
    data_addr = da;
    data_wdata = dwd;
    data_wstrb = dws;
    while (pend_i || pend_d) begin
      win_d = pend_d && (!pend_i || !m_last_d);
      lat = win_d ? ld : li;
      resp_lat = lat;
      resp_rdata = win_d ? md : mi;
      resp_err = win_d ? ed : ei;
      tmo = lat > TO - 1;
      rdv = tmo ? 32'h0 : resp_rdata;
      erv = tmo ? 2'b11 : resp_err;
      wait_ready(cyc, gi, gd);
      check("latency", 64'(cyc), 64'((tmo ? TO - 1 : lat) + (first ? 2 : 3)));
      check("winner", {gi, gd}, win_d ? 64'b01 : 64'b10);
      check("grant_cycles", 64'(last_run), 64'(tmo ? TO : lat + 1));
      check("mem_addr", log_addr, win_d ? {da[31:2], 2'b00} : {ia[31:2], 2'b00});
      check("mem_we", 64'(log_we), 64'(win_d && dwe));
      check("mem_wstrb", 64'(log_wstrb), (win_d && dwe) ? 64'(dws) : 64'd0);
      if (win_d && dwe) check("mem_wdata", log_wdata, dwd);
      if (win_d) begin
        m_drd = rdv;
        m_derr = erv;
      end else begin
        m_ird = rdv;
        m_ierr = erv;
      end
      check("inst_rdata", inst_rdata, m_ird);
      check("inst_error", inst_error, m_ierr);
      check("data_rdata", data_rdata, m_drd);
      check("data_error", data_error, m_derr);
      m_last_d = win_d;
      if (win_d) begin
        data_req = 1'b0;
        pend_d = 1'b0;
      end else begin
        inst_req = 1'b0;
        pend_i = 1'b0;
      end
      first = 1'b0;
    end
    @(negedge clk);
    check("pulse_width", {inst_ready, data_ready}, 64'd0);
  endtask

  initial begin
    int cyc;
    bit gi, gd;
    repeat (3) @(negedge clk);
    check("rst_outputs", {mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, inst_ready,
                          data_ready}, 64'd0);
    check("rst_rdata", {inst_rdata, data_rdata}, 64'd0);
    check("rst_error", {inst_error, data_error}, 64'd0);
    rstn = 1'b1;

    // Stray mem_ready while idle has no effect
    stray_en = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("stray_idle", {mem_valid, inst_ready, data_ready, inst_rdata, data_rdata}, 64'd0);
    end
    stray_en = 1'b0;

    // Single fetch, single write, timeout, memory error, ready on timeout cycle
    round(1, 32'h0000_1003, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0);
    round(0, 0, 1, 1, 32'h20, 32'h1234_5678, 4'b0101, 0, 0, 0, 0, 32'h5555_AAAA, 2'b00);
    round(0, 0, 1, 0, 32'h44, 32'hFFFF_FFFF, 4'b1111, 0, 0, 0, 100, 32'hCAFE_F00D, 2'b00);
    round(1, 32'h0000_2008, 0, 0, 0, 0, 0, 2, 32'h0BAD_0BAD, 2'b01, 0, 0, 0);
    round(0, 0, 1, 0, 32'h83, 0, 4'b1111, 0, 0, 0, TO - 1, 32'h7777_1234, 2'b00);
    round(1, 32'h0000_300C, 0, 0, 0, 0, 0, TO - 1, 32'h1357_9BDF, 2'b10, 0, 0, 0);

    // Reset during a data grant
    data_req = 1'b1;
    data_we = 1'b0;
    data_addr = 32'h100;
    resp_lat = 100;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_valid_before", 64'(mem_valid), 64'd1);
    #2 rstn = 1'b0;
    #1 check("rst_mid_valid_async", 64'(mem_valid), 64'd0);
    data_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_mid_no_ready", {inst_ready, data_ready, mem_valid}, 64'd0);
    end
    rstn = 1'b1;
    model_reset();
    @(negedge clk);
    check("rst_mid_idle", {inst_ready, data_ready, mem_valid}, 64'd0);

    // Contention from reset: INST, DATA, INST, DATA
    round(1, 32'h0000_4000, 1, 0, 32'h0000_5000, 0, 4'b1111, 0, 32'hA1, 0, 0, 32'hB1, 0);
    round(1, 32'h0000_4004, 1, 1, 32'h0000_5004, 32'h99, 4'b0011, 1, 32'hA2, 0, 2, 32'hB2, 0);

    // Randomized rounds with stray mem_ready outside grants
    stray_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      int sel;
      sel = $urandom_range(1, 3);
      round(sel[0], $urandom, sel[1], 1'($urandom), $urandom, $urandom, 4'($urandom),
            $urandom_range(0, 9), $urandom, 2'($urandom),
            $urandom_range(0, 9), $urandom, 2'($urandom));
    end
    stray_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog in case the bench itself stalls.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench timeout");
  end

endmodule
